// File: rtl/intercal_alu_seq.sv
// INTERCAL-style ALU: single-cycle unary/mingle ops plus a bit-serial select
// (op 11 over W bits, op 10 per half) behind a valid/ready handshake.
module intercal_alu_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] f,
    output logic         busy
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W);

    generate
        if ((W % 2) != 0 || W < 4) begin : g_bad_width
            $error("intercal_alu_seq: W must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    f_q, f_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            half_q, half_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   ptr_lo_q, ptr_lo_d;
    logic [CW-1:0]   ptr_hi_q, ptr_hi_d;

    logic [W-1:0]    ror_w, ror_h, mingle_lo, mingle_hi, op_result;
    logic [CW-1:0]   hi_pos, hi_idx, last_cnt;
    logic            accept, is_sel;

    // Rotate right by one, over the full word or within each half.
    assign ror_w = {a[0], a[W-1:1]};
    assign ror_h = {a[H], a[W-1:H+1], a[0], a[H-1:1]};

    generate
        for (genvar gi = 0; gi < H; gi++) begin : g_mingle
            assign mingle_lo[2*gi+1] = a[gi];
            assign mingle_lo[2*gi]   = b[gi];
            assign mingle_hi[2*gi+1] = a[H+gi];
            assign mingle_hi[2*gi]   = b[H+gi];
        end
    endgenerate

    always_comb begin
        op_result = '0;
        case (s)
            4'd0:    op_result = a;
            4'd1:    op_result = b;
            4'd2:    op_result = ror_h & a;
            4'd3:    op_result = ror_w & a;
            4'd4:    op_result = ror_h | a;
            4'd5:    op_result = ror_w | a;
            4'd6:    op_result = ror_h ^ a;
            4'd7:    op_result = ror_w ^ a;
            4'd8:    op_result = mingle_lo;
            4'd9:    op_result = mingle_hi;
            default: op_result = '0;
        endcase
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_sel    = (s[3:1] == 3'b101);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SCAN);
    assign f         = f_q;

    assign hi_pos   = cnt_q + CW'(H);
    assign hi_idx   = ptr_hi_q + CW'(H);
    assign last_cnt = half_q ? CW'(H - 1) : CW'(W - 1);

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        ptr_lo_d = ptr_lo_q;
        ptr_hi_d = ptr_hi_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_sel) begin
                        state_d  = SCAN;
                        a_d      = a;
                        b_d      = b;
                        half_d   = ~s[0];
                        acc_d    = '0;
                        cnt_d    = '0;
                        ptr_lo_d = '0;
                        ptr_hi_d = '0;
                    end else begin
                        state_d = DONE;
                        f_d     = op_result;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // One bit position per edge; in half mode the upper half runs in lockstep.
                if (b_q[cnt_q]) begin
                    acc_d[ptr_lo_q] = a_q[cnt_q];
                    ptr_lo_d        = ptr_lo_q + CW'(1);
                end
                if (half_q && b_q[hi_pos]) begin
                    acc_d[hi_idx] = a_q[hi_pos];
                    ptr_hi_d      = ptr_hi_q + CW'(1);
                end
                if (cnt_q == last_cnt) begin
                    state_d = DONE;
                    f_d     = acc_d;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            f_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            half_q   <= 1'b0;
            cnt_q    <= '0;
            ptr_lo_q <= '0;
            ptr_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            ptr_lo_q <= ptr_lo_d;
            ptr_hi_q <= ptr_hi_d;
        end
    end
endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed bench for intercal_alu_seq (W=32) with hand-computed expected values.
module tb_intercal_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        busy;

    int checks = 0;
    int errors = 0;

    intercal_alu_seq #(.W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Single-cycle op: result and out_valid on the accepting edge, then consumed.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp);
        in_valid = 1'b1; s = op; a = av; b = bv;
        tick;
        in_valid = 1'b0;
        check(tag, f, exp);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Select op: exact latency, busy/in_ready/f behaviour during the scan.
    task automatic run_scan(input string tag, input logic [3:0] op,
                            input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] exp, input int lat);
        logic [31:0] f0;
        int n, bc;
        bit rdy, fch;
        f0 = f;
        in_valid = 1'b1; s = op; a = av; b = bv;
        tick;
        // Keep requesting with different operands; these must be ignored.
        s = 4'd1; a = 32'hFFFF_FFFF; b = 32'hDEAD_BEEF;
        n = 0; bc = 0; rdy = 0; fch = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bc++;
            if (in_ready !== 1'b0) rdy = 1;
            if (f !== f0) fch = 1;
            tick;
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_cycles"}, bc, lat);
        check({tag, "_ready_in_scan"}, {31'd0, rdy}, 32'd0);
        check({tag, "_f_moved_in_scan"}, {31'd0, fch}, 32'd0);
        check({tag, "_result"}, f, exp);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick;
        tick;
        check({tag, "_hold_f"}, f, exp);
        check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        bit stable, seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        s = 4'd0; a = '0; b = '0;
        #2;
        check("rst_f", f, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        tick;
        rst = 1'b0;

        // First acceptance on the first edge after reset release.
        run_op("op3_and",    4'd3,  32'h8000_0001, 32'h0, 32'h8000_0000);
        run_op("op0_a",      4'd0,  32'h1234_5678, 32'h9, 32'h1234_5678);
        run_op("op1_b",      4'd1,  32'h9, 32'h0000_0055, 32'h0000_0055);
        run_op("op3_and_b",  4'd3,  32'hC000_0003, 32'h0, 32'hC000_0001);
        run_op("op2_and_h",  4'd2,  32'hC000_0003, 32'h0, 32'h4000_0001);
        run_op("op5_or",     4'd5,  32'h0000_0001, 32'h0, 32'h8000_0001);
        run_op("op4_or_h",   4'd4,  32'h0001_0001, 32'h0, 32'h8001_8001);
        run_op("op7_xor",    4'd7,  32'hF0F0_F0F0, 32'h0, 32'h8888_8888);
        run_op("op6_xor_h",  4'd6,  32'h0003_0003, 32'h0, 32'h8002_8002);
        run_op("op8_mingle", 4'd8,  32'h0000_FFFF, 32'h0, 32'hAAAA_AAAA);
        run_op("op8_mingle_b", 4'd8, 32'h0, 32'h0000_FFFF, 32'h5555_5555);
        run_op("op9_mingle", 4'd9,  32'hFFFF_0000, 32'h0, 32'hAAAA_AAAA);
        run_op("op14_zero",  4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        run_scan("op11_sel",      4'd11, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0000_A5A5, 32);
        run_scan("op10_sel",      4'd10, 32'h1234_5678, 32'hFFFF_000F, 32'h1234_0008, 16);
        run_scan("op11_sel_spread", 4'd11, 32'h8000_0003, 32'h8000_0101, 32'h0000_0005, 32);
        run_scan("op10_sel_b0",   4'd10, 32'hFFFF_FFFF, 32'h0, 32'h0, 16);

        // Backpressure: result held, requests ignored, then back-to-back handoff.
        in_valid = 1'b1; s = 4'd7; a = 32'hF0F0_F0F0; b = 32'h0;
        tick;
        s = 4'd0; a = 32'h0000_0123;
        stable = 1;
        repeat (5) begin
            tick;
            if (f !== 32'h8888_8888 || out_valid !== 1'b1) stable = 0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        check("bp_f", f, 32'h8888_8888);
        out_ready = 1'b1; s = 4'd1; b = 32'h0000_0055;
        tick;
        check("bp_nobubble_f", f, 32'h0000_0055);
        check("bp_nobubble_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a select scan.
        in_valid = 1'b1; s = 4'd11; a = 32'hA5A5_A5A5; b = 32'hFFFF_FFFF;
        tick;
        in_valid = 1'b0;
        repeat (10) tick;
        check("mid_scan_busy", {31'd0, busy}, 32'd1);
        held = f;
        check("mid_scan_f_held", held, 32'h0000_0055);
        rst = 1'b1;
        #1;
        check("arst_f", f, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; s = 4'd0; a = 32'h7;
        tick;
        check("arst_no_accept", {31'd0, out_valid}, 32'd0);
        check("arst_no_accept_f", f, 32'd0);
        rst = 1'b0; a = 32'h1;
        tick;
        in_valid = 1'b0;
        check("post_rst_f", f, 32'h0000_0001);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        seen = 0;
        repeat (40) begin
            tick;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        check("post_rst_quiet", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
